// File: rtl/parity_pkg.sv
// ============================================================================
// parity_pkg : shared types and line-level constants for the parity link
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package parity_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        PAR   = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    localparam int ERRCNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/parity_acc.sv
// ============================================================================
// parity_acc : 1-bit XOR accumulator with synchronous clear and enable
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    input  logic d_i,
    output logic acc_o
);

    logic acc_q;
    logic acc_d;

    // Clear wins over enable so a new frame always starts from zero parity.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = 1'b0;
        end else if (en_i) begin
            acc_d = acc_q ^ d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/parity_rx.sv
// ============================================================================
// parity_rx : serial start/data/parity/stop receiver with even-parity check
// Optional error counter output enabled by PARITY_RX_ERRCNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module parity_rx
    import parity_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en_i,
    input  logic              rxd_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              perr_o,
    output logic              ferr_o,
    output logic              ovr_o
`ifdef PARITY_RX_ERRCNT_EN
   ,output logic [ERRCNT_W-1:0] err_cnt_o
`endif
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    rx_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  shift_nxt;
    logic               acc_clr, acc_en, acc;
    logic               load;

    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;
    logic               hs;

    // Bits arrive LSB first, so each new bit enters at the MSB and slides down.
    generate
        if (DATA_W == 1) begin : g_shift_w1
            assign shift_nxt = rxd_i;
        end else begin : g_shift_wn
            assign shift_nxt = {rxd_i, shift_q[DATA_W-1:1]};
        end
    endgenerate

    parity_acc u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (acc_clr),
        .en_i  (acc_en),
        .d_i   (rxd_i),
        .acc_o (acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        load    = 1'b0;
        if (bit_en_i) begin
            case (state_q)
                IDLE: begin
                    if (rxd_i == START_LEVEL) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        acc_clr = 1'b1;
                    end
                end
                DATA: begin
                    shift_d = shift_nxt;
                    acc_en  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = PAR;
                    end
                end
                PAR: begin
                    acc_en  = 1'b1;
                    state_d = STOP;
                end
                STOP: begin
                    load    = 1'b1;
                    state_d = (rxd_i == STOP_LEVEL) ? IDLE : BREAK;
                end
                BREAK: begin
                    if (rxd_i == IDLE_LEVEL) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign hs = valid_q & ready_i;

    // A load always wins over a handshake; overrun only when the old word is lost.
    always_comb begin
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (load) begin
            data_d  = shift_q;
            perr_d  = acc;
            ferr_d  = (rxd_i != STOP_LEVEL);
            valid_d = 1'b1;
        end else if (hs) begin
            valid_d = 1'b0;
        end
        if (load && valid_q && !ready_i) begin
            ovr_d = 1'b1;
        end else if (hs) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign perr_o  = perr_q;
    assign ferr_o  = ferr_q;
    assign ovr_o   = ovr_q;

`ifdef PARITY_RX_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (load && (acc || (rxd_i != STOP_LEVEL)) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

`default_nettype wire
